// File: rtl/stack_lifo_ctrl.sv
// ---------------------------------------------------------------------------
// stack_lifo_ctrl
//
// Parametrised LIFO stack with status flags, replace-top (push+pop), peek,
// synchronous flush and single-cycle error pulses. Storage is a plain
// register array with no reset, so it maps onto distributed RAM.
//
// Optional feature macro: STACK_WATERMARK_EN
//   When defined, adds output high_water: the largest count seen since reset
//   or since the last flush. It is registered one edge behind count.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   push         write dataIn on top of the stack
//   pop          remove the top entry and return it on dataOut
//   peak         return the top entry on dataOut without removing it
//   flush        synchronous clear (highest priority)
//   dataIn       data to push
//   dataOut      registered read data (1-cycle latency)
//   data_valid   one-cycle pulse: dataOut was updated
//   count        number of entries held
//   empty        count == 0
//   full         count == STACK_depth
//   almost_full  count >= almost_full_lvl
//   overflow     one-cycle pulse: push rejected (stack full)
//   underflow    one-cycle pulse: pop or peak rejected (stack empty)
//   high_water   (STACK_WATERMARK_EN only) peak occupancy
//
// Request/response contract: a request is sampled on a rising edge; its
// response (data_valid/overflow/underflow and the new count) is visible for
// exactly the following cycle. There is no backpressure; one request may be
// issued every cycle.
//
// The first edge after reset release is always ignored (r_run is still 0),
// so a request presented as rst_n deasserts never takes effect.
// ---------------------------------------------------------------------------
module stack_lifo_ctrl #(
    parameter int data_width      = 8,
    parameter int STACK_depth     = 8,
    parameter int almost_full_lvl = STACK_depth - 1,
    localparam int CW             = $clog2(STACK_depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  peak,
    input  logic                  flush,
    input  logic [data_width-1:0] dataIn,
    output logic [data_width-1:0] dataOut,
    output logic                  data_valid,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
`ifdef STACK_WATERMARK_EN
    ,
    output logic [CW-1:0]         high_water
`endif
);

    localparam int AW = $clog2(STACK_depth);
    localparam logic [CW-1:0] CNT_MAX = CW'(STACK_depth);
    localparam logic [CW-1:0] CNT_AF  = CW'(almost_full_lvl);

    logic [data_width-1:0] r_mem [STACK_depth];
    logic [CW-1:0]         r_count;
    logic [data_width-1:0] r_dout;
    logic                  r_dv;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_run;

    logic                  w_empty;
    logic                  w_full;
    logic [AW-1:0]         w_top_addr;
    logic [AW-1:0]         w_wr_addr;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_ovf;
    logic                  w_unf;
    logic [CW-1:0]         w_count_nxt;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_MAX);
    // Only used when the stack is non-empty, so the wrap at count==0 is harmless.
    assign w_top_addr = AW'(r_count - CW'(1));

    // Goes high one edge after reset release; gates every request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Request decode, priority flush > push&pop > push > pop > peak.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = AW'(r_count);
        w_rd_en     = 1'b0;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_count_nxt = r_count;
        if (r_run) begin
            if (flush) begin
                w_count_nxt = '0;
            end else if (push && pop) begin
                if (w_empty) begin
                    // Nothing to return: behave as a push but flag the pop.
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                    w_unf       = 1'b1;
                end else begin
                    // Replace-top: read old top and overwrite it on the same edge.
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_top_addr;
                    w_rd_en   = 1'b1;
                end
            end else if (push) begin
                if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    w_unf = 1'b1;
                end else begin
                    w_rd_en     = 1'b1;
                    w_count_nxt = r_count - CW'(1);
                end
            end else if (peak) begin
                if (w_empty) begin
                    w_unf = 1'b1;
                end else begin
                    w_rd_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dv    <= w_rd_en;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
            if (w_rd_en) begin
                r_dout <= r_mem[w_top_addr];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= dataIn;
        end
    end

`ifdef STACK_WATERMARK_EN
    logic [CW-1:0] r_high_water;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_water <= '0;
        end else if (r_run && flush) begin
            r_high_water <= '0;
        end else if (r_count > r_high_water) begin
            r_high_water <= r_count;
        end
    end

    assign high_water = r_high_water;
`endif

    assign dataOut     = r_dout;
    assign data_valid  = r_dv;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CNT_AF);

endmodule

// File: tb/tb_stack_lifo_ctrl.sv
module tb_stack_lifo_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic push = 1'b0, pop = 1'b0, peak = 1'b0, flush = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic [DW-1:0] dataOut;
  logic data_valid, empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] count;
`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] high_water;
`endif

  stack_lifo_ctrl #(.data_width(DW), .STACK_depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .peak(peak), .flush(flush),
    .dataIn(dataIn), .dataOut(dataOut), .data_valid(data_valid), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
`ifdef STACK_WATERMARK_EN
    , .high_water(high_water)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Count plus the flags derived from it, plus the error pulses.
  task automatic chk_st(input string nm, input int c, input bit ov, input bit un);
    chk({nm, " count"}, 32'(count), 32'(c));
    chk({nm, " empty"}, 32'(empty), 32'(c == 0));
    chk({nm, " full"}, 32'(full), 32'(c == DEPTH));
    chk({nm, " almost_full"}, 32'(almost_full), 32'(c >= DEPTH - 1));
    chk({nm, " overflow"}, 32'(overflow), 32'(ov));
    chk({nm, " underflow"}, 32'(underflow), 32'(un));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives the request, returns at the next falling
  // edge when the response is visible.
  task automatic op(input logic i_push, input logic i_pop, input logic i_peak,
                    input logic i_flush, input logic [DW-1:0] din);
    push = i_push; pop = i_pop; peak = i_peak; flush = i_flush; dataIn = din;
    @(negedge clk);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_data_valid: dataOut 0x%0h with nothing expected at %0t",
                 dataOut, $time);
      end else begin
        chk("read_data", 32'(dataOut), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_st("reset", 0, 1'b0, 1'b0);
    chk("reset dataOut", 32'(dataOut), 32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    rst_n = 1'b1;
    idle();

    // LIFO ordering
    op(1, 0, 0, 0, 8'h11); chk_st("push1", 1, 0, 0);
    op(1, 0, 0, 0, 8'h22); chk_st("push2", 2, 0, 0);
    op(1, 0, 0, 0, 8'h33); chk_st("push3", 3, 0, 0);
    exp_q.push_back(8'h33); op(0, 1, 0, 0, 8'h00); chk_st("pop1", 2, 0, 0);
    exp_q.push_back(8'h22); op(0, 1, 0, 0, 8'h00); chk_st("pop2", 1, 0, 0);
    exp_q.push_back(8'h11); op(0, 1, 0, 0, 8'h00); chk_st("pop3", 0, 0, 0);

    // Fill to full, then overflow
    for (int i = 1; i <= 9; i++) begin
      op(1, 0, 0, 0, 8'(8'h40 + i));
      chk_st($sformatf("fill%0d", i), (i > DEPTH) ? DEPTH : i, i > DEPTH, 1'b0);
    end
    idle(); chk_st("after_overflow", DEPTH, 0, 0);
    exp_q.push_back(8'h48); op(0, 1, 0, 0, 8'h00); chk_st("pop_after_full", 7, 0, 0);
    op(0, 0, 0, 1, 8'h00); chk_st("flush1", 0, 0, 0);
    chk("flush holds dataOut", 32'(dataOut), 32'h48);

    // Underflow on empty
    op(0, 1, 0, 0, 8'h00); chk_st("pop_empty", 0, 0, 1);
    chk("pop_empty dataOut", 32'(dataOut), 32'h48);
    op(0, 0, 1, 0, 8'h00); chk_st("peak_empty", 0, 0, 1);
    chk("peak_empty dataOut", 32'(dataOut), 32'h48);
    idle(); chk_st("underflow_cleared", 0, 0, 0);

    // Replace-top and peek
    op(1, 0, 0, 0, 8'hA5); chk_st("push_a5", 1, 0, 0);
    exp_q.push_back(8'hA5); op(1, 1, 0, 0, 8'h5A); chk_st("replace_top", 1, 0, 0);
    exp_q.push_back(8'h5A); op(0, 0, 1, 0, 8'h00); chk_st("peak_5a", 1, 0, 0);
    op(0, 0, 0, 1, 8'h00); chk_st("flush2", 0, 0, 0);
    op(1, 1, 0, 0, 8'h77); chk_st("pushpop_empty", 1, 0, 1);
    exp_q.push_back(8'h77); op(0, 0, 1, 0, 8'h00); chk_st("peak_77", 1, 0, 0);
    op(0, 0, 0, 1, 8'h00); chk_st("flush3", 0, 0, 0);

    // Flush beats a simultaneous push
    for (int i = 1; i <= 5; i++) op(1, 0, 0, 0, 8'(i));
    idle(); chk_st("five_entries", 5, 0, 0);
`ifdef STACK_WATERMARK_EN
    chk("high_water before flush", 32'(high_water), 32'd5);
`endif
    op(1, 0, 0, 1, 8'hEE); chk_st("flush_with_push", 0, 0, 0);
    idle(); chk_st("after_flush_push", 0, 0, 0);
`ifdef STACK_WATERMARK_EN
    chk("high_water after flush", 32'(high_water), 32'd0);
`endif

    // Asynchronous reset mid-burst
    for (int i = 1; i <= 4; i++) op(1, 0, 0, 0, 8'(8'hC0 + i));
    exp_q.push_back(8'hC4); op(0, 0, 1, 0, 8'h00); chk_st("peak_c4", 4, 0, 0);
    push = 1'b0; peak = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_st("async_reset", 0, 0, 0);
    chk("async_reset dataOut", 32'(dataOut), 32'h0);
    chk("async_reset data_valid", 32'(data_valid), 32'h0);
    push = 1'b1; dataIn = 8'h99;
    @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push = 1'b0;
    chk_st("release_edge_push_ignored", 0, 0, 0);
    idle(); chk_st("still_empty", 0, 0, 0);
    op(1, 0, 0, 0, 8'h12); chk_st("push_after_reset", 1, 0, 0);
    exp_q.push_back(8'h12); op(0, 1, 0, 0, 8'h00); chk_st("pop_after_reset", 0, 0, 0);
    idle();
    idle();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
